jesd204b_scrambler_mx: RTL and testbench



---
 rtl/jesd204b_pkg.sv | 7 +
 rtl/jesd204b_scr_lane.sv | 46 ++++
 rtl/jesd204b_scrambler_mx.sv | 60 ++++++
 tb/tb_jesd204b_scrambler_mx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_pkg.sv
// Shared constants for the JESD204B self-synchronous scrambler (1 + x^14 + x^15).
package jesd204b_pkg;
  localparam int JESD_SCR_STATE_W = 15;
  localparam logic [JESD_SCR_STATE_W-1:0] JESD_SCR_SEED = 15'h7f80;
  localparam int JESD_SCR_TAP_A = 14;
  localparam int JESD_SCR_TAP_B = 15;
endpackage

// File: rtl/jesd204b_scr_lane.sv
// One scrambler/descrambler lane: flattened XOR network plus the 15-bit history register.
module jesd204b_scr_lane
  import jesd204b_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [JESD_SCR_STATE_W-1:0] SEED = JESD_SCR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              descr,
  input  logic              seed_load,
  input  logic              upd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [JESD_SCR_STATE_W-1:0] st_reg;
  logic [JESD_SCR_STATE_W-1:0] st_cur;
  logic [DATA_W+JESD_SCR_STATE_W-1:0] x;
  logic fb;

  // x holds the scrambled bit stream: previous word's history above the current word.
  always_comb begin
    st_cur = seed_load ? SEED : st_reg;
    x = '0;
    dout = '0;
    fb = 1'b0;
    x[DATA_W +: JESD_SCR_STATE_W] = st_cur;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = x[i + JESD_SCR_TAP_A] ^ x[i + JESD_SCR_TAP_B];
      dout[i] = din[i] ^ fb;
      x[i] = descr ? din[i] : dout[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_reg <= SEED;
    end else if (upd) begin
      st_reg <= x[JESD_SCR_STATE_W-1:0];
    end else if (seed_load) begin
      st_reg <= SEED;
    end
  end

endmodule

// File: rtl/jesd204b_scrambler_mx.sv
// Multi-lane JESD204B scrambler/descrambler with a single registered valid/ready stage.
module jesd204b_scrambler_mx
  import jesd204b_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DATA_W = 32,
  parameter logic [JESD_SCR_STATE_W-1:0] SEED = JESD_SCR_SEED
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_descr,
  input  logic                    cfg_bypass,
  input  logic                    seed_load,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data
);

  logic accept;
  logic upd;
  logic [LANES*DATA_W-1:0] lane_data;

  assign in_ready = ~out_valid | out_ready;
  assign accept = in_valid & in_ready;
  // Lane history is frozen while bypassing; seed_load still applies.
  assign upd = accept & ~cfg_bypass;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      jesd204b_scr_lane #(
        .DATA_W(DATA_W),
        .SEED  (SEED)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .descr    (cfg_descr),
        .seed_load(seed_load),
        .upd      (upd),
        .din      (in_data[gi*DATA_W +: DATA_W]),
        .dout     (lane_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= cfg_bypass ? in_data : lane_data;
      end
    end
  end

endmodule

// File: tb/tb_jesd204b_scrambler_mx.sv
// Scoreboard bench for jesd204b_scrambler_mx: driver queues expected beats, monitor checks them.
module tb_jesd204b_scrambler_mx;
  localparam int LANES = 4;
  localparam int DW = 32;
  localparam int BW = LANES * DW;
  localparam int SW = 15;
  localparam logic [SW-1:0] SEED = 15'h7f80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_descr = 1'b0;
  logic cfg_bypass = 1'b0;
  logic seed_load = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [BW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [BW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  bit bp_en = 1'b0;
  bit hold_low = 1'b0;

  typedef struct {
    logic [BW-1:0] data;
    bit            chk;
  } exp_t;
  exp_t exp_q[$];

  logic [LANES*SW-1:0] mst;
  logic [LANES*SW-1:0] tst;
  logic [LANES*SW-1:0] nst;

  jesd204b_scrambler_mx #(.LANES(LANES), .DATA_W(DW), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_descr (cfg_descr),
    .cfg_bypass(cfg_bypass),
    .seed_load (seed_load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = hold_low ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Bit-serial reference: r[j] is the scrambled bit sent j+1 bits ago.
  function automatic logic [BW-1:0] model(input logic [LANES*SW-1:0] st_in,
                                          input logic [BW-1:0] d, input bit descr,
                                          output logic [LANES*SW-1:0] st_out);
    logic [BW-1:0] o;
    logic [SW-1:0] r;
    logic sb, fb;
    o = '0;
    st_out = '0;
    for (int k = 0; k < LANES; k++) begin
      r = st_in[k*SW +: SW];
      for (int i = DW - 1; i >= 0; i--) begin
        fb = r[13] ^ r[14];
        sb = descr ? d[k*DW+i] : d[k*DW+i] ^ fb;
        o[k*DW+i] = d[k*DW+i] ^ fb;
        r = {r[13:0], sb};
      end
      st_out[k*SW +: SW] = r;
    end
    return o;
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] b;
    for (int k = 0; k < LANES; k++) b[k*DW +: DW] = $urandom();
    return b;
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end else begin
      $display("ok   %s %h", nm, got);
    end
  endtask

  task automatic send(input logic [BW-1:0] d, input logic [BW-1:0] e, input bit c, input bit sl);
    int n;
    bit ok;
    exp_t ent;
    in_data = d;
    in_valid = 1'b1;
    seed_load = sl;
    n = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end else begin
      ent.data = e;
      ent.chk = c;
      exp_q.push_back(ent);
    end
    in_valid = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
  endtask

  // Monitor: pops on every transfer, and checks the output is held while stalled.
  logic [BW-1:0] held;
  bit stall_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) chk("beat", out_data, e.data);
          else $display("skip beat %h", out_data);
        end
      end
      if (out_valid && !out_ready) begin
        if (stall_prev) chk("stall_hold", out_data, held);
        held = out_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [BW-1:0] d, s, e, z, k1, k2, v;
    z = '0;
    k1 = {LANES{32'h0100_0600}};
    k2 = {LANES{32'h1400_7801}};

    #12;
    v = '0; v[0] = out_valid; chk("rst_out_valid", v, z);
    chk("rst_out_data", out_data, z);
    v = '0; v[0] = in_ready; e = '0; e[0] = 1'b1; chk("rst_in_ready", v, e);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Scramble from SEED: two hand-computed beats.
    send(z, k1, 1'b1, 1'b0);
    send(z, k2, 1'b1, 1'b0);
    drain();

    // Descramble from SEED, then a stream scrambled by the reference.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cfg_descr = 1'b1;
    send(k1, z, 1'b1, 1'b0);
    tst = {LANES{15'h0600}};
    for (int b = 0; b < 8; b++) begin
      d = rnd_bus();
      s = model(tst, d, 1'b0, nst);
      tst = nst;
      send(s, d, 1'b1, 1'b0);
    end

    // Corrupt the descrambler history with junk, then check it resyncs after one beat.
    send(rnd_bus(), z, 1'b0, 1'b0);
    for (int b = 0; b < 6; b++) begin
      d = rnd_bus();
      s = model(tst, d, 1'b0, nst);
      tst = nst;
      send(s, d, b > 0, 1'b0);
    end
    drain();

    // Scramble under random backpressure must match the no-stall reference.
    cfg_descr = 1'b0;
    seed_load = 1'b1;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    mst = {LANES{SEED}};
    bp_en = 1'b1;
    for (int b = 0; b < 20; b++) begin
      d = rnd_bus();
      e = model(mst, d, 1'b0, nst);
      mst = nst;
      send(d, e, 1'b1, 1'b0);
    end
    bp_en = 1'b0;
    drain();

    // Bypass passes data through and leaves lane history untouched.
    cfg_bypass = 1'b1;
    for (int b = 0; b < 3; b++) begin
      d = rnd_bus();
      send(d, d, 1'b1, 1'b0);
    end
    drain();
    cfg_bypass = 1'b0;
    d = rnd_bus();
    e = model(mst, d, 1'b0, nst);
    mst = nst;
    send(d, e, 1'b1, 1'b0);

    // seed_load coincident with an accepted beat uses SEED for that beat.
    send(z, k1, 1'b1, 1'b1);
    send(z, k2, 1'b1, 1'b0);
    drain();

    // Reset while a beat is stalled in the output register.
    hold_low = 1'b1;
    @(posedge clk);
    #1;
    send(rnd_bus(), z, 1'b0, 1'b0);
    @(negedge clk);
    v = '0; v[0] = out_valid; e = '0; e[0] = 1'b1; chk("stalled_valid", v, e);
    #2;
    reset = 1'b1;
    #1;
    v = '0; v[0] = out_valid; chk("async_rst_valid", v, z);
    chk("async_rst_data", out_data, z);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    hold_low = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    send(z, k1, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
